axi_slv_model: RTL and testbench

Parametrised, synthesizable AXI slave model for crossbar verification. It accepts AW/W/AR traffic with configurable ready backpressure and returns B/R responses carrying the request ID. Read data follows a deterministic, address-derived pattern, and errors are flagged for a programmable address window. It connects to each crossbar slave port in the bench and replaces free-running random stubs.

---
 rtl/axi_slv_model_pkg.sv | 9 +
 rtl/axi_slv_model_fifo.sv | 40 ++++
 rtl/axi_slv_model.sv | 144 ++++++++++++++
 tb/tb_axi_slv_model.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_model_pkg.sv
// axi_slv_model_pkg: shared response codes, LFSR polynomial and address-window helper for axi_slv_model
package axi_slv_model_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  function automatic logic in_win(input logic [63:0] a, input logic [63:0] lo, input logic [63:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction
endpackage

// File: rtl/axi_slv_model_fifo.sv
// axi_slv_model_fifo: power-of-two FIFO with registered full/empty and simultaneous push/pop
module axi_slv_model_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt, cnt_nxt;
  logic do_push, do_pop;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign cnt_nxt = cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
  assign dout = mem[rp];
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp <= wp + PW'(do_push);
      rp <= rp + PW'(do_pop);
      cnt <= cnt_nxt;
      full <= cnt_nxt == (PW+1)'(D);
      empty <= cnt_nxt == '0;
    end
  always_ff @(posedge aclk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/axi_slv_model.sv
// axi_slv_model: AXI slave model with LFSR backpressure, ID-echoing B/R, pattern read data and SLVERR window.
// Define AXI_SLV_MODEL_RD_LAT_EN to hold off each read burst's first beat by RD_LAT cycles.
module axi_slv_model
  import axi_slv_model_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W = 4,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W = 4,
  parameter int WR_OSTD_NUM = 4,
  parameter int RD_OSTD_NUM = 4,
  parameter int READY_MODE = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [AXI_ADDR_W-1:0] ERR_BASE = 'hF000_0000,
  parameter logic [AXI_ADDR_W-1:0] ERR_LIMIT = 'hFFFF_FFFF,
  parameter int RD_LAT = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  in_awvalid,
  output logic                  out_awready,
  input  logic [AXI_ID_W-1:0]   in_awid,
  input  logic [AXI_ADDR_W-1:0] in_awaddr,
  input  logic [AXI_LEN_W-1:0]  in_awlen,
  input  logic                  in_wvalid,
  output logic                  out_wready,
  input  logic                  in_wlast,
  output logic                  out_bvalid,
  input  logic                  in_bready,
  output logic [AXI_ID_W-1:0]   out_bid,
  output logic [1:0]            out_bresp,
  input  logic                  in_arvalid,
  output logic                  out_arready,
  input  logic [AXI_ID_W-1:0]   in_arid,
  input  logic [AXI_ADDR_W-1:0] in_araddr,
  input  logic [AXI_LEN_W-1:0]  in_arlen,
  output logic                  out_rvalid,
  input  logic                  in_rready,
  output logic [AXI_ID_W-1:0]   out_rid,
  output logic [AXI_DATA_W-1:0] out_rdata,
  output logic [1:0]            out_rresp,
  output logic                  out_rlast,
  output logic                  out_wlast_err
);
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [AXI_LEN_W-1:0] len;
    logic err;
  } aw_t;
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0] resp;
  } b_t;
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0] len;
    logic err;
  } ar_t;
`ifdef AXI_SLV_MODEL_RD_LAT_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif
  function automatic logic gate(input logic [1:0] b);
    return READY_MODE == 0 ? 1'b1 : READY_MODE == 1 ? b[0] : |b;
  endfunction
  logic [15:0] lfsr;
  aw_t aw_din, aw_head;
  b_t b_din, b_head;
  ar_t ar_din, ar_head;
  logic aw_full, aw_empty, b_full, b_empty, ar_full, ar_empty;
  logic aw_hs, w_hs, b_pop, ar_hs, r_hs, ar_pop, b_push;
  logic last_beat, wlast_bad, werr, rd_ok;
  logic [AXI_LEN_W-1:0] wcnt, rbeat;
  logic [AXI_ADDR_W-1:0] raddr;
  logic unused_lfsr;
  assign unused_lfsr = ^{lfsr[15:10], lfsr[7:6], lfsr[3:2]};
  always_ff @(posedge aclk or posedge areset)
    if (areset) lfsr <= LFSR_SEED;
    else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0);
  assign out_awready = !areset & !aw_full & gate(lfsr[1:0]);
  assign out_wready = !areset & !aw_empty & !b_full & gate(lfsr[5:4]);
  assign out_arready = !areset & !ar_full & gate(lfsr[9:8]);
  assign aw_hs = in_awvalid & out_awready;
  assign w_hs = in_wvalid & out_wready;
  assign ar_hs = in_arvalid & out_arready;
  assign aw_din = '{id: in_awid, len: in_awlen, err: in_win(64'(in_awaddr), 64'(ERR_BASE), 64'(ERR_LIMIT))};
  assign ar_din = '{id: in_arid, addr: in_araddr, len: in_arlen, err: in_win(64'(in_araddr), 64'(ERR_BASE), 64'(ERR_LIMIT))};
  axi_slv_model_fifo #(.W($bits(aw_t)), .D(WR_OSTD_NUM)) u_aw_fifo (
    .aclk(aclk), .areset(areset), .push(aw_hs), .din(aw_din), .pop(b_push),
    .dout(aw_head), .full(aw_full), .empty(aw_empty)
  );
  // wlast only flags errors; the burst length always comes from the AW entry
  assign last_beat = wcnt == aw_head.len;
  assign wlast_bad = w_hs & (in_wlast != last_beat);
  assign b_push = w_hs & last_beat;
  assign b_din = '{id: aw_head.id, resp: (aw_head.err | werr | wlast_bad) ? RESP_SLVERR : RESP_OKAY};
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      wcnt <= '0;
      werr <= 1'b0;
      out_wlast_err <= 1'b0;
    end else begin
      if (w_hs) wcnt <= last_beat ? '0 : wcnt + 1'b1;
      if (w_hs) werr <= last_beat ? 1'b0 : werr | wlast_bad;
      out_wlast_err <= out_wlast_err | wlast_bad;
    end
  axi_slv_model_fifo #(.W($bits(b_t)), .D(WR_OSTD_NUM)) u_b_fifo (
    .aclk(aclk), .areset(areset), .push(b_push), .din(b_din), .pop(b_pop),
    .dout(b_head), .full(b_full), .empty(b_empty)
  );
  assign out_bvalid = !b_empty;
  assign b_pop = out_bvalid & in_bready;
  assign out_bid = b_empty ? '0 : b_head.id;
  assign out_bresp = b_empty ? RESP_OKAY : b_head.resp;
  axi_slv_model_fifo #(.W($bits(ar_t)), .D(RD_OSTD_NUM)) u_ar_fifo (
    .aclk(aclk), .areset(areset), .push(ar_hs), .din(ar_din), .pop(ar_pop),
    .dout(ar_head), .full(ar_full), .empty(ar_empty)
  );
  generate
    if (LAT_EN && RD_LAT > 0) begin : g_lat
      logic [$clog2(RD_LAT+1)-1:0] lat_cnt;
      always_ff @(posedge aclk or posedge areset)
        if (areset) lat_cnt <= '0;
        else if (ar_pop) lat_cnt <= '0;
        else if (!ar_empty && lat_cnt != $bits(lat_cnt)'(RD_LAT)) lat_cnt <= lat_cnt + 1'b1;
      assign rd_ok = lat_cnt == $bits(lat_cnt)'(RD_LAT);
    end else begin : g_nolat
      assign rd_ok = 1'b1;
    end
  endgenerate
  assign out_rvalid = !ar_empty & rd_ok;
  assign r_hs = out_rvalid & in_rready;
  assign ar_pop = r_hs & out_rlast;
  assign raddr = ar_head.addr + AXI_ADDR_W'(rbeat) * AXI_ADDR_W'(AXI_DATA_W / 8);
  assign out_rdata = out_rvalid ? AXI_DATA_W'(raddr) : '0;
  assign out_rid = out_rvalid ? ar_head.id : '0;
  assign out_rresp = (out_rvalid & ar_head.err) ? RESP_SLVERR : RESP_OKAY;
  assign out_rlast = out_rvalid & (rbeat == ar_head.len);
  always_ff @(posedge aclk or posedge areset)
    if (areset) rbeat <= '0;
    else if (r_hs) rbeat <= out_rlast ? '0 : rbeat + 1'b1;
endmodule

// File: tb/tb_axi_slv_model.sv
// tb_axi_slv_model: scoreboard bench for axi_slv_model (READY_MODE=1, default widths)
module tb_axi_slv_model;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0] resp;
    logic last;
  } r_t;
  logic aclk = 0, areset = 1;
  logic in_awvalid = 0, in_wvalid = 0, in_wlast = 0, in_bready = 1, in_arvalid = 0, in_rready = 1;
  logic [IW-1:0] in_awid = 0, in_arid = 0;
  logic [AW-1:0] in_awaddr = 0, in_araddr = 0;
  logic [LW-1:0] in_awlen = 0, in_arlen = 0;
  logic out_awready, out_wready, out_bvalid, out_arready, out_rvalid, out_rlast, out_wlast_err;
  logic [IW-1:0] out_bid, out_rid;
  logic [1:0] out_bresp, out_rresp;
  logic [DW-1:0] out_rdata;
  int n_chk = 0, n_err = 0;
  logic [IW+1:0] exp_b[$];
  r_t exp_r[$];
  r_t held;
  bit hold_v = 0;
  bit rnd_rready = 0;
  always #5 aclk = ~aclk;
  axi_slv_model #(.READY_MODE(1)) dut (
    .aclk(aclk), .areset(areset),
    .in_awvalid(in_awvalid), .out_awready(out_awready), .in_awid(in_awid), .in_awaddr(in_awaddr), .in_awlen(in_awlen),
    .in_wvalid(in_wvalid), .out_wready(out_wready), .in_wlast(in_wlast),
    .out_bvalid(out_bvalid), .in_bready(in_bready), .out_bid(out_bid), .out_bresp(out_bresp),
    .in_arvalid(in_arvalid), .out_arready(out_arready), .in_arid(in_arid), .in_araddr(in_araddr), .in_arlen(in_arlen),
    .out_rvalid(out_rvalid), .in_rready(in_rready), .out_rid(out_rid), .out_rdata(out_rdata),
    .out_rresp(out_rresp), .out_rlast(out_rlast), .out_wlast_err(out_wlast_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge aclk) begin
    if (areset) hold_v = 0;
    else begin
      if (hold_v) check("r_hold", {out_rvalid, out_rid, out_rdata, out_rresp, out_rlast}, {1'b1, held});
      hold_v = out_rvalid && !in_rready;
      held = '{out_rid, out_rdata, out_rresp, out_rlast};
      if (out_bvalid && in_bready) begin
        if (exp_b.size() == 0) check("b_unexp", {out_bid, out_bresp}, 64'hdead);
        else check("b", {out_bid, out_bresp}, exp_b.pop_front());
      end
      if (out_rvalid && in_rready) begin
        if (exp_r.size() == 0) check("r_unexp", {out_rid, out_rdata}, 64'hdead);
        else check("r", {out_rid, out_rdata, out_rresp, out_rlast}, exp_r.pop_front());
      end
    end
  end
  initial forever begin
    @(posedge aclk);
    #1;
    in_rready = rnd_rready ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic hs(input int ch);
    int n = 0;
    logic r;
    while (1) begin
      @(negedge aclk);
      r = ch == 0 ? out_awready : ch == 1 ? out_wready : out_arready;
      if (r) break;
      n++;
      if (n > 200) begin
        check("hs_timeout", 64'(ch), 64'hff);
        break;
      end
    end
    @(posedge aclk);
    #1;
  endtask
  task automatic do_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    in_awvalid = 1;
    in_awid = id;
    in_awaddr = addr;
    in_awlen = len;
    hs(0);
    in_awvalid = 0;
  endtask
  task automatic do_w(input logic [IW-1:0] id, input int len, input bit err, input int wl);
    exp_b.push_back({id, (err || wl != len) ? 2'b10 : 2'b00});
    for (int i = 0; i <= len; i++) begin
      in_wvalid = 1;
      in_wlast = (i == wl);
      hs(1);
    end
    in_wvalid = 0;
    in_wlast = 0;
  endtask
  task automatic do_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len);
    for (int i = 0; i <= len; i++)
      exp_r.push_back('{id, addr + 32'(4 * i), addr >= 32'hF000_0000 ? 2'b10 : 2'b00, i == len});
    in_arvalid = 1;
    in_arid = id;
    in_araddr = addr;
    in_arlen = LW'(len);
    hs(2);
    in_arvalid = 0;
  endtask
  task automatic wait_drain(input string tag);
    int n = 0;
    do begin
      @(posedge aclk);
      n++;
    end while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 1000);
    #1;
    check(tag, 64'(exp_b.size() + exp_r.size()), 0);
  endtask
  initial begin
    #12;
    check("rst_awready", out_awready, 0);
    check("rst_wready", out_wready, 0);
    check("rst_arready", out_arready, 0);
    check("rst_bvalid", out_bvalid, 0);
    check("rst_rvalid", out_rvalid, 0);
    check("rst_rlast", out_rlast, 0);
    check("rst_ids", {out_bid, out_bresp, out_rid, out_rdata, out_rresp}, 0);
    check("rst_wlast_err", out_wlast_err, 0);
    @(posedge aclk);
    #1;
    areset = 0;
    do_aw(3, 32'h100, 3);
    do_w(3, 3, 0, 3);
    wait_drain("t1_drain");
    check("t1_wlast_err", out_wlast_err, 0);
    do_ar(5, 32'h200, 2);
    wait_drain("t2_drain");
    do_ar(6, 32'hF000_0010, 0);
    do_aw(9, 32'hF000_0000, 0);
    do_w(9, 0, 1, 0);
    wait_drain("t3_drain");
    check("t3_wlast_err", out_wlast_err, 0);
    do_aw(7, 32'h300, 1);
    do_w(7, 1, 0, 0);
    wait_drain("t4_drain");
    check("t4_wlast_err", out_wlast_err, 1);
    do_aw(8, 32'h304, 1);
    do_w(8, 1, 0, 1);
    wait_drain("t4_next_drain");
    check("t4_sticky", out_wlast_err, 1);
    in_bready = 0;
    for (int i = 0; i < 4; i++) do_aw(IW'(i), 32'h400 + 32'(16 * i), 0);
    in_awvalid = 1;
    in_awid = 4'hE;
    repeat (4) begin
      @(negedge aclk);
      check("t5_aw_full", out_awready, 0);
    end
    @(posedge aclk);
    #1;
    in_awvalid = 0;
    for (int i = 0; i < 4; i++) do_w(IW'(i), 0, 0, 0);
    do_aw(4, 32'h440, 0);
    do_aw(5, 32'h450, 0);
    in_wvalid = 1;
    in_wlast = 1;
    repeat (4) begin
      @(negedge aclk);
      check("t5_b_full", out_wready, 0);
      check("t5_bvalid", out_bvalid, 1);
    end
    @(posedge aclk);
    #1;
    in_wvalid = 0;
    in_bready = 1;
    do_w(4, 0, 0, 0);
    do_w(5, 0, 0, 0);
    wait_drain("t5_drain");
    rnd_rready = 1;
    do_ar(10, 32'h500, 7);
    do_aw(11, 32'h600, 1);
    in_wvalid = 1;
    in_wlast = 0;
    hs(1);
    in_wvalid = 0;
    repeat (2) @(posedge aclk);
    #3;
    areset = 1;
    #1;
    check("t6_rvalid", out_rvalid, 0);
    check("t6_bvalid", out_bvalid, 0);
    check("t6_readies", {out_awready, out_wready, out_arready}, 0);
    check("t6_rlast", out_rlast, 0);
    check("t6_wlast_err", out_wlast_err, 0);
    exp_r.delete();
    exp_b.delete();
    @(posedge aclk);
    #1;
    areset = 0;
    @(negedge aclk);
    check("t6_empty", {out_rvalid, out_bvalid}, 0);
    @(posedge aclk);
    #1;
    do_ar(13, 32'h800, 1);
    do_aw(12, 32'h700, 1);
    do_w(12, 1, 0, 1);
    wait_drain("t6_drain");
    check("t6_post_wlast_err", out_wlast_err, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
